instr_sequencer: RTL

- Multicycle fetch/decode/writeback controller that sits directly upstream of the 8-entry register file.
- Fetches 12-bit instructions from an instruction-memory port with a valid handshake, holds them in an instruction register and drives the register file's opcode and RD/RA/RB/RF address inputs.
- Resolves branches using the register file's RF read port.
- Gates opcode so that a register write occurs for exactly one cycle per write-class instruction.

---
 rtl/instr_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Multicycle fetch/decode/writeback controller in front of the 8-entry register file.
// Fetches 4*m-bit instructions over a valid handshake, holds them in IR, and drives the
// register file's opcode and address fields. Branches test the RF read port.
module instr_sequencer #(
  parameter int unsigned m = 3,
  parameter int unsigned n = 2 * m
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           imem_req,
  output logic [n-1:0]   imem_addr,
  input  logic           imem_valid,
  input  logic [4*m-1:0] imem_data,
  output logic [m-1:0]   opcode,
  output logic [m-1:0]   RDAddress,
  output logic [m-1:0]   RAAddress,
  output logic [m-1:0]   RBAddress,
  output logic [m-1:0]   RFAddress,
  input  logic [n-1:0]   RFContents,
  output logic [n-1:0]   pc,
  output logic [7:0]     instr_count,
  output logic           halted
);

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StWb, StHalt} state_e;

  localparam logic [m-1:0] OpNop  = m'(0);
  localparam logic [m-1:0] OpAlu1 = m'(1);
  localparam logic [m-1:0] OpAlu2 = m'(2);
  localparam logic [m-1:0] OpAlu3 = m'(3);
  localparam logic [m-1:0] OpAlu4 = m'(4);
  localparam logic [m-1:0] OpBz   = m'(5);
  localparam logic [m-1:0] OpJmp  = m'(6);
  localparam logic [m-1:0] OpHalt = m'(7);

  state_e         state_q;
  logic [n-1:0]   pc_q;
  logic [4*m-1:0] ir_q;
  logic [7:0]     count_q;
  logic [m-1:0]   opcode_q;
  logic           req_q;
  logic           halted_q;

  logic [m-1:0]   ir_op;
  logic [n-1:0]   target;
  logic [n-1:0]   pc_inc;

  assign ir_op  = ir_q[4*m-1:3*m];
  // Branch/jump target is the RD field followed by the RB field.
  assign target = {ir_q[3*m-1:2*m], ir_q[m-1:0]};
  assign pc_inc = pc_q + n'(1);

  // Address fields always come from IR so they stay stable through DECODE and WB.
  assign RDAddress   = ir_q[3*m-1:2*m];
  assign RAAddress   = ir_q[2*m-1:m];
  assign RBAddress   = ir_q[m-1:0];
  assign RFAddress   = ir_q[2*m-1:m];
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_count = count_q;
  assign opcode      = opcode_q;
  assign imem_req    = req_q;
  assign halted      = halted_q;

  // Controller FSM with registered opcode/request/halt outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      ir_q     <= '0;
      count_q  <= '0;
      opcode_q <= '0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFetch;
            req_q   <= 1'b1;
          end
        end
        StFetch: begin
          if (imem_valid) begin
            ir_q    <= imem_data;
            state_q <= StDecode;
            req_q   <= 1'b0;
          end
        end
        StDecode: begin
          case (ir_op)
            OpAlu1, OpAlu2, OpAlu3, OpAlu4: begin
              // Opcode is presented only during WB so exactly one write commits.
              opcode_q <= ir_op;
              state_q  <= StWb;
            end
            OpBz: begin
              pc_q    <= (RFContents == '0) ? target : pc_inc;
              count_q <= count_q + 8'd1;
              state_q <= StFetch;
              req_q   <= 1'b1;
            end
            OpJmp: begin
              pc_q    <= target;
              count_q <= count_q + 8'd1;
              state_q <= StFetch;
              req_q   <= 1'b1;
            end
            OpHalt: begin
              // pc is left pointing at the HALT instruction.
              count_q  <= count_q + 8'd1;
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end
            OpNop: begin
              pc_q    <= pc_inc;
              count_q <= count_q + 8'd1;
              state_q <= StFetch;
              req_q   <= 1'b1;
            end
            default: begin
              pc_q    <= pc_inc;
              count_q <= count_q + 8'd1;
              state_q <= StFetch;
              req_q   <= 1'b1;
            end
          endcase
        end
        StWb: begin
          opcode_q <= '0;
          pc_q     <= pc_inc;
          count_q  <= count_q + 8'd1;
          state_q  <= StFetch;
          req_q    <= 1'b1;
        end
        StHalt: begin
          // Only reset leaves HALT.
          state_q <= StHalt;
        end
        default: begin
          state_q  <= StIdle;
          opcode_q <= '0;
          req_q    <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
